tx_seq_frame_gen: RTL and testbench
===================================

# tx_seq_frame_gen

Transmit-side test-frame generator for the loss-measurement link. Emits fixed-length payload frames byte by byte toward the TX MAC/CRC stage. Each frame carries a 16-bit segment number and a 16-bit aux sequence number at fixed byte offsets. Segment runs 0..segment_number_max-1 inside each aux value; aux runs 0..MAXAUX and wraps. These are exactly the fields the receive-side error/loss detector decodes to count ok/ng/lost frames.

## Interface
- PAYLOAD_LEN, 64: bytes per frame; must be ≥ 4.
- AUX_POS, 0: byte offset of aux[15:8]; aux[7:0] at AUX_POS+1.
- SEG_POS, 2: byte offset of seg[15:8]; seg[7:0] at SEG_POS+1.
- GAP_CYCLES, 12: idle cycles after each frame; must be ≥ 1.
- MAXAUX, 16'h0fff: last aux value before wrap to 0.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-high.
- enable  in  1  level; permits starting new frames.
- frame_limit  in  32  frames to send before DONE; 0 = unlimited.
- segment_number_max  in  16  segments per aux; 0 treated as 1.
- tx_valid  out  1  tx_data/tx_last valid.
- tx_ready  in  1  downstream accepts byte when tx_valid && tx_ready.
- tx_data  out  8  payload byte.
- tx_last  out  1  high on final byte of a frame.
- seg_out  out  16  segment number of current/next frame.
- aux_out  out  16  aux number of current/next frame.
- frames_sent  out  32  completed frames since reset.
- done  out  1  frame_limit reached.
- state  out  2  FSM state for debug.

## Operation
- States: IDLE=0, SEND=1, GAP=2, DONE=3.
- Reset: state IDLE; tx_valid, tx_last, done = 0; tx_data, seg_out, aux_out, frames_sent, byte index, gap counter = 0.
- IDLE: if enable, go to SEND. Latch segment_number_max, mapping 0 to 1.
- SEND: tx_valid=1. tx_data by byte index i:
  - i==AUX_POS: aux[15:8]; i==AUX_POS+1: aux[7:0].
  - i==SEG_POS: seg[15:8]; i==SEG_POS+1: seg[7:0].
  - otherwise i[7:0].
  - If the aux and seg fields overlap, aux wins.
- Holding: tx_data and tx_last hold stable while tx_valid && !tx_ready. i advances only on acceptance.
- Last byte: tx_last=1 when i==PAYLOAD_LEN-1. On its acceptance:
  - frames_sent += 1 (32-bit, wraps); i clears; go to GAP.
  - Advance seg: if seg == latched max-1, seg becomes 0 and aux advances; else seg+1.
  - aux advances to 0 after MAXAUX, else aux+1.
- GAP: tx_valid=0 for GAP_CYCLES cycles. Then:
  - frame_limit≠0 and frames_sent≥frame_limit: DONE.
  - else enable: SEND, re-latching segment_number_max.
  - else: IDLE.
- DONE: done=1, tx_valid=0. Held until rst.
- Mid-frame changes:
  - enable deassert: current frame completes; no new frame starts.
  - segment_number_max change: takes effect at next frame start.
  - frame_limit change: compared only at end of GAP.
- rst mid-frame: frame abandoned immediately (tx_valid=0 next cycle), all counters cleared.
- Elaboration errors: AUX_POS+1 or SEG_POS+1 ≥ PAYLOAD_LEN.

## Timing
- enable sampled high in IDLE at cycle N → first byte valid at N+1.
- With tx_ready held at 1, a frame occupies PAYLOAD_LEN cycles.
- Frame-to-frame period: PAYLOAD_LEN + GAP_CYCLES cycles.
- seg_out, aux_out and frames_sent update in the cycle after the last byte is accepted.
- done asserts on the cycle after GAP ends.
- All outputs registered. No combinational path from tx_ready to tx_valid. tx_data may change only on acceptance or state change.

## Structure
- Shared package holds:
  - state encodings IDLE/SEND/GAP/DONE;
  - default MAXAUX;
  - a field-offset function used by both this block and the RX detector, so aux/seg positions agree.
- One sub-module: seq_counter_2d. It handles the seg/aux nested wrap counter (advance strobe, latched seg max, MAXAUX wrap) and is reusable by the RX side for expected-sequence tracking.

## Test plan
- PAYLOAD_LEN=64, AUX_POS=0, SEG_POS=2, segment_number_max=4, tx_ready=1, enable=1:
  - frame 0 bytes: 00 00 00 00 04 05 …3F;
  - frame 5 carries aux=0001, seg=0001;
  - frame period 76 cycles.
- MAXAUX=2, segment_number_max=2, run 7 frames → (aux,seg) = 00/0,00/1,01/0,01/1,02/0,02/1,00/0.
- tx_ready random 50% → byte order/values identical to the ready=1 run; tx_data stable whenever tx_valid && !tx_ready.
- frame_limit=3 → exactly 3 tx_last pulses; done=1 and state=3 after 3rd GAP; frames_sent=3; enable toggling thereafter has no effect.
- segment_number_max=0 → seg always 0 and aux increments every frame.
- Mid-frame events:
  - enable dropped at byte 10 → frame completes, then IDLE after GAP;
  - rst at byte 20 → tx_valid=0 next cycle and all outputs zero.

Source files
------------

// File: rtl/tx_seq_frame_gen_pkg.sv
// Shared definitions for the loss-measurement test-frame generator and its RX detector:
// FSM encodings, default aux wrap point and the payload field layout.
package tx_seq_frame_gen_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEND = 2'd1,
    ST_GAP  = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  localparam logic [15:0] DEFAULT_MAXAUX = 16'h0fff;

  // Byte found at payload offset idx. Aux is tested first so it wins if the fields overlap;
  // the RX detector decodes with this same function so both sides agree on positions.
  function automatic logic [7:0] field_byte(input int unsigned idx,
                                            input int unsigned aux_pos,
                                            input int unsigned seg_pos,
                                            input logic [15:0] aux,
                                            input logic [15:0] seg);
    logic [7:0] b;
    if (idx == aux_pos)          b = aux[15:8];
    else if (idx == aux_pos + 1) b = aux[7:0];
    else if (idx == seg_pos)     b = seg[15:8];
    else if (idx == seg_pos + 1) b = seg[7:0];
    else                         b = idx[7:0];
    return b;
  endfunction

endpackage

// File: rtl/tx_seq_frame_gen_seq_counter_2d.sv
// Nested seg/aux sequence counter: seg wraps at the latched segment count and carries into aux,
// which wraps after MAXAUX. Shared with the RX side for expected-sequence tracking.
module seq_counter_2d
  import tx_seq_frame_gen_pkg::*;
#(
  parameter logic [15:0] MAXAUX = DEFAULT_MAXAUX
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        load_max,
  input  logic [15:0] seg_max_in,
  input  logic        advance,
  output logic [15:0] seg,
  output logic [15:0] aux
);

  logic [15:0] seg_max;

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      seg     <= '0;
      aux     <= '0;
      seg_max <= 16'd1;
    end else begin
      // A zero segment count would never wrap, so it is treated as one segment per aux.
      if (load_max) seg_max <= (seg_max_in == 16'd0) ? 16'd1 : seg_max_in;
      if (advance) begin
        if (seg == seg_max - 16'd1) begin
          seg <= '0;
          aux <= (aux == MAXAUX) ? 16'd0 : aux + 16'd1;
        end else begin
          seg <= seg + 16'd1;
        end
      end
    end
  end

endmodule

// File: rtl/tx_seq_frame_gen.sv
// Test-frame generator: emits fixed-length payload frames carrying seg/aux sequence fields,
// separated by idle gaps, optionally stopping after frame_limit frames.
module tx_seq_frame_gen
  import tx_seq_frame_gen_pkg::*;
#(
  parameter int unsigned PAYLOAD_LEN = 64,
  parameter int unsigned AUX_POS     = 0,
  parameter int unsigned SEG_POS     = 2,
  parameter int unsigned GAP_CYCLES  = 12,
  parameter logic [15:0] MAXAUX      = DEFAULT_MAXAUX
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable,
  input  logic [31:0] frame_limit,
  input  logic [15:0] segment_number_max,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic [7:0]  tx_data,
  output logic        tx_last,
  output logic [15:0] seg_out,
  output logic [15:0] aux_out,
  output logic [31:0] frames_sent,
  output logic        done,
  output logic [1:0]  state
);

  localparam int unsigned IDX_W = $clog2(PAYLOAD_LEN);
  localparam int unsigned GAP_W = $clog2(GAP_CYCLES + 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(PAYLOAD_LEN - 1);
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_CYCLES - 1);

  if (PAYLOAD_LEN < 4) begin : g_bad_len
    $error("PAYLOAD_LEN must be at least 4");
  end
  if (GAP_CYCLES < 1) begin : g_bad_gap
    $error("GAP_CYCLES must be at least 1");
  end
  if (AUX_POS + 1 >= PAYLOAD_LEN) begin : g_bad_aux
    $error("aux field does not fit in the payload");
  end
  if (SEG_POS + 1 >= PAYLOAD_LEN) begin : g_bad_seg
    $error("seg field does not fit in the payload");
  end

  state_t           state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d, idx_nxt;
  logic [GAP_W-1:0] gap_q, gap_d;
  logic             tx_valid_d, tx_last_d, done_d;
  logic [7:0]       tx_data_d;
  logic [31:0]      frames_d;
  logic             load_max, advance, start;

  seq_counter_2d #(.MAXAUX(MAXAUX)) u_seq (
    .clk        (clk),
    .rst        (rst),
    .load_max   (load_max),
    .seg_max_in (segment_number_max),
    .advance    (advance),
    .seg        (seg_out),
    .aux        (aux_out)
  );

  assign idx_nxt = idx_q + IDX_W'(1);
  assign state   = state_q;

  // NOTE: every signal gets a default before the case so no path leaves it unassigned (no latches).
  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    gap_d      = gap_q;
    tx_valid_d = tx_valid;
    tx_data_d  = tx_data;
    tx_last_d  = tx_last;
    done_d     = done;
    frames_d   = frames_sent;
    load_max   = 1'b0;
    advance    = 1'b0;
    start      = 1'b0;

    unique case (state_q)
      ST_IDLE: start = enable;
      ST_SEND: begin
        // tx_valid is always high here, so tx_ready alone marks acceptance.
        if (tx_ready) begin
          if (idx_q == LAST_IDX) begin
            advance    = 1'b1;
            frames_d   = frames_sent + 32'd1;
            idx_d      = '0;
            gap_d      = '0;
            tx_valid_d = 1'b0;
            tx_last_d  = 1'b0;
            state_d    = ST_GAP;
          end else begin
            idx_d     = idx_nxt;
            tx_data_d = field_byte(32'(idx_nxt), AUX_POS, SEG_POS, aux_out, seg_out);
            tx_last_d = (idx_nxt == LAST_IDX);
          end
        end
      end
      ST_GAP: begin
        if (gap_q == GAP_LAST) begin
          if (frame_limit != 32'd0 && frames_sent >= frame_limit) begin
            state_d = ST_DONE;
            done_d  = 1'b1;
          end else if (enable) begin
            start = 1'b1;
          end else begin
            state_d = ST_IDLE;
          end
        end else begin
          gap_d = gap_q + GAP_W'(1);
        end
      end
      ST_DONE: ;
      default: ;
    endcase

    // Frame start: seg/aux already reflect the previous frame's advance.
    if (start) begin
      state_d    = ST_SEND;
      load_max   = 1'b1;
      idx_d      = '0;
      tx_valid_d = 1'b1;
      tx_last_d  = 1'b0;
      tx_data_d  = field_byte(32'd0, AUX_POS, SEG_POS, aux_out, seg_out);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      idx_q       <= '0;
      gap_q       <= '0;
      tx_valid    <= 1'b0;
      tx_data     <= '0;
      tx_last     <= 1'b0;
      done        <= 1'b0;
      frames_sent <= '0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      gap_q       <= gap_d;
      tx_valid    <= tx_valid_d;
      tx_data     <= tx_data_d;
      tx_last     <= tx_last_d;
      done        <= done_d;
      frames_sent <= frames_d;
    end
  end

endmodule

// File: tb/tb_tx_seq_frame_gen.sv
// Self-checking bench: a frame-level behavioural model predicts every output each cycle,
// and directed scenarios pin the model with hand-computed values.
module tb_tx_seq_frame_gen;

  localparam int PL     = 64;
  localparam int AP     = 0;
  localparam int SP     = 2;
  localparam int GAP    = 12;
  localparam int MAXAUX = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        enable = 1'b0;
  logic        tx_ready = 1'b1;
  logic [31:0] frame_limit = '0;
  logic [15:0] segment_number_max = 16'd4;
  logic        tx_valid, tx_last, done;
  logic [7:0]  tx_data;
  logic [15:0] seg_out, aux_out;
  logic [31:0] frames_sent;
  logic [1:0]  state;

  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;
  bit mon_on = 1'b0;
  logic [7:0] acc_q[$];
  logic [7:0] ref_q[$];
  int last_cnt = 0;
  int exp_aux[7] = '{0, 0, 1, 1, 2, 2, 0};
  int exp_seg[7] = '{0, 1, 0, 1, 0, 1, 0};

  tx_seq_frame_gen #(
    .PAYLOAD_LEN (PL),
    .AUX_POS     (AP),
    .SEG_POS     (SP),
    .GAP_CYCLES  (GAP),
    .MAXAUX      (16'(MAXAUX))
  ) dut (
    .clk                (clk),
    .rst                (rst),
    .enable             (enable),
    .frame_limit        (frame_limit),
    .segment_number_max (segment_number_max),
    .tx_valid           (tx_valid),
    .tx_ready           (tx_ready),
    .tx_data            (tx_data),
    .tx_last            (tx_last),
    .seg_out            (seg_out),
    .aux_out            (aux_out),
    .frames_sent        (frames_sent),
    .done               (done),
    .state              (state)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  typedef struct packed {
    logic [1:0]  st;
    logic        valid;
    logic        last;
    logic        done;
    logic [7:0]  data;
    logic [31:0] pos;
    logic [31:0] gap_left;
    logic [31:0] seg;
    logic [31:0] aux;
    logic [31:0] segmax;
    logic [31:0] frames;
  } model_t;

  model_t m;

  // Whole frame image: counting bytes, seg field laid on top, then aux on top of that.
  function automatic logic [7:0] img_byte(input logic [31:0] i, input logic [31:0] aux,
                                          input logic [31:0] seg);
    logic [7:0] img [PL];
    for (int k = 0; k < PL; k++) img[k] = 8'(k);
    img[SP]     = seg[15:8];
    img[SP + 1] = seg[7:0];
    img[AP]     = aux[15:8];
    img[AP + 1] = aux[7:0];
    return img[int'(i)];
  endfunction

  function automatic model_t start_frame(input model_t c, input logic [15:0] smax);
    model_t n = c;
    n.segmax = (smax == 16'd0) ? 32'd1 : 32'(smax);
    n.st     = 2'd1;
    n.valid  = 1'b1;
    n.last   = 1'b0;
    n.pos    = 0;
    n.data   = img_byte(0, c.aux, c.seg);
    return n;
  endfunction

  function automatic model_t model_next(input model_t c, input logic r, input logic en,
                                        input logic rdy, input logic [31:0] lim,
                                        input logic [15:0] smax);
    model_t n = c;
    if (r) begin
      n = '0;
      n.segmax = 1;
      return n;
    end
    case (c.st)
      2'd0: if (en) n = start_frame(c, smax);
      2'd1: if (rdy) begin
        if (c.pos == PL - 1) begin
          n.frames   = c.frames + 1;
          n.valid    = 1'b0;
          n.last     = 1'b0;
          n.st       = 2'd2;
          n.gap_left = GAP;
          n.pos      = 0;
          n.seg      = (c.seg + 1) % c.segmax;
          if (n.seg == 0) n.aux = (c.aux + 1) % (MAXAUX + 1);
        end else begin
          n.pos  = c.pos + 1;
          n.data = img_byte(n.pos, c.aux, c.seg);
          n.last = (n.pos == PL - 1);
        end
      end
      2'd2: begin
        n.gap_left = c.gap_left - 1;
        if (n.gap_left == 0) begin
          if (lim != 0 && c.frames >= lim) begin
            n.st   = 2'd3;
            n.done = 1'b1;
          end else if (en) begin
            n = start_frame(n, smax);
          end else begin
            n.st = 2'd0;
          end
        end
      end
      default: ;
    endcase
    return n;
  endfunction

  always @(posedge clk) m <= model_next(m, rst, enable, tx_ready, frame_limit, segment_number_max);

  // ---------------- per-cycle compare ----------------
  logic       prev_valid = 1'b0, prev_ready = 1'b0, prev_last = 1'b0, prev_rst = 1'b1;
  logic [7:0] prev_data = '0;

  always @(negedge clk) begin
    if (mon_on) begin
      check("mon_state",  32'(state),       32'(m.st));
      check("mon_valid",  32'(tx_valid),    32'(m.valid));
      check("mon_done",   32'(done),        32'(m.done));
      check("mon_frames", frames_sent,      m.frames);
      check("mon_seg",    32'(seg_out),     m.seg);
      check("mon_aux",    32'(aux_out),     m.aux);
      if (m.valid) begin
        check("mon_data", 32'(tx_data), 32'(m.data));
        check("mon_last", 32'(tx_last), 32'(m.last));
      end
      if (prev_valid && !prev_ready && !prev_rst && tx_valid) begin
        check("hold_data", 32'(tx_data), 32'(prev_data));
        check("hold_last", 32'(tx_last), 32'(prev_last));
      end
    end
    prev_valid <= tx_valid;
    prev_ready <= tx_ready;
    prev_data  <= tx_data;
    prev_last  <= tx_last;
    prev_rst   <= rst;
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    enable = 1'b0;
    rst    = 1'b1;
    tick();
    tick();
    rst    = 1'b0;
  endtask

  task automatic wait_valid(input int budget, output int t);
    int n = 0;
    while (!tx_valid && n < budget) begin
      tick();
      n++;
    end
    check("wait_valid_in_budget", 32'(n < budget), 1);
    t = cyc;
  endtask

  // Runs until frames_sent reaches n_frames, collecting accepted bytes and tx_last acceptances.
  task automatic drive_frames(input int n_frames, input bit rand_ready, input int budget);
    int n = 0;
    while (frames_sent < 32'(n_frames) && n < budget) begin
      tx_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      if (tx_valid && tx_ready) begin
        acc_q.push_back(tx_data);
        if (tx_last) last_cnt++;
      end
      tick();
      n++;
    end
    tx_ready = 1'b1;
    check("frames_in_budget", 32'(n < budget), 1);
  endtask

  initial begin
    int t0, t1, t;

    // Reset state
    tick();
    tick();
    check("rst_valid",  32'(tx_valid), 0);
    check("rst_last",   32'(tx_last), 0);
    check("rst_data",   32'(tx_data), 0);
    check("rst_seg",    32'(seg_out), 0);
    check("rst_aux",    32'(aux_out), 0);
    check("rst_frames", frames_sent, 0);
    check("rst_done",   32'(done), 0);
    check("rst_state",  32'(state), 0);
    rst    = 1'b0;
    mon_on = 1'b1;

    // Frame 0 layout and frame period with segment_number_max=4, ready=1
    segment_number_max = 16'd4;
    enable = 1'b1;
    wait_valid(20, t0);
    for (int i = 0; i < PL; i++) begin
      check("f0_byte", 32'(tx_data), (i < 4) ? 0 : i);
      if (i == PL - 1) check("f0_last", 32'(tx_last), 1);
      tick();
    end
    wait_valid(100, t1);
    check("frame_period", t1 - t0, 76);

    // Frame 5 carries aux=0001, seg=0001
    drive_frames(5, 1'b0, 600);
    wait_valid(50, t);
    check("f5_aux_out", 32'(aux_out), 1);
    check("f5_seg_out", 32'(seg_out), 1);
    check("f5_b0", 32'(tx_data), 32'h00);
    tick();
    check("f5_b1", 32'(tx_data), 32'h01);
    tick();
    check("f5_b2", 32'(tx_data), 32'h00);
    tick();
    check("f5_b3", 32'(tx_data), 32'h01);

    // MAXAUX=2, segment_number_max=2: seven-frame (aux,seg) sequence including the wrap
    do_reset();
    segment_number_max = 16'd2;
    enable = 1'b1;
    for (int k = 0; k < 7; k++) begin
      wait_valid(200, t);
      check("seq_aux", 32'(aux_out), exp_aux[k]);
      check("seq_seg", 32'(seg_out), exp_seg[k]);
      drive_frames(k + 1, 1'b0, 200);
    end

    // Random back-pressure yields the same byte stream as ready=1
    do_reset();
    segment_number_max = 16'(1 + $urandom_range(0, 4));
    acc_q.delete();
    enable = 1'b1;
    drive_frames(3, 1'b0, 600);
    enable = 1'b0;
    ref_q = acc_q;
    do_reset();
    acc_q.delete();
    enable = 1'b1;
    drive_frames(3, 1'b1, 3000);
    enable = 1'b0;
    check("stream_len", acc_q.size(), 192);
    check("stream_len_ref", ref_q.size(), 192);
    for (int i = 0; i < acc_q.size() && i < ref_q.size(); i++)
      check("stream_byte", 32'(acc_q[i]), 32'(ref_q[i]));

    // frame_limit=3 ends in DONE, insensitive to enable afterwards
    do_reset();
    frame_limit = 32'd3;
    segment_number_max = 16'd3;
    last_cnt = 0;
    enable = 1'b1;
    drive_frames(3, 1'b1, 3000);
    begin
      int n = 0;
      while (!done && n < 50) begin
        tick();
        n++;
      end
      check("done_in_budget", 32'(n < 50), 1);
    end
    check("lim_done",   32'(done), 1);
    check("lim_state",  32'(state), 3);
    check("lim_frames", frames_sent, 3);
    check("lim_lasts",  last_cnt, 3);
    for (int i = 0; i < 40; i++) begin
      enable   = 1'($urandom_range(0, 1));
      tx_ready = 1'($urandom_range(0, 1));
      tick();
    end
    tx_ready = 1'b1;
    check("lim_hold_state",  32'(state), 3);
    check("lim_hold_valid",  32'(tx_valid), 0);
    check("lim_hold_frames", frames_sent, 3);

    // segment_number_max=0: seg stays 0 and aux steps every frame (wrapping after 2)
    do_reset();
    frame_limit = '0;
    segment_number_max = 16'd0;
    enable = 1'b1;
    drive_frames(1, 1'b0, 200);
    check("sm0_seg1", 32'(seg_out), 0);
    check("sm0_aux1", 32'(aux_out), 1);
    drive_frames(2, 1'b0, 200);
    check("sm0_aux2", 32'(aux_out), 2);
    drive_frames(3, 1'b0, 200);
    check("sm0_seg3", 32'(seg_out), 0);
    check("sm0_aux3", 32'(aux_out), 0);

    // enable dropped at byte 10: frame completes, then IDLE after the gap
    do_reset();
    segment_number_max = 16'd4;
    enable = 1'b1;
    wait_valid(20, t);
    repeat (10) tick();
    check("en_drop_byte10", 32'(tx_data), 32'h0a);
    enable = 1'b0;
    drive_frames(1, 1'b0, 200);
    check("en_drop_frames", frames_sent, 1);
    repeat (GAP + 2) tick();
    check("en_drop_state", 32'(state), 0);
    check("en_drop_valid", 32'(tx_valid), 0);

    // rst at byte 20: everything cleared on the next cycle
    enable = 1'b1;
    wait_valid(20, t);
    repeat (20) tick();
    check("rst_mid_byte20", 32'(tx_data), 32'h14);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    enable = 1'b0;
    check("rst_mid_valid",  32'(tx_valid), 0);
    check("rst_mid_last",   32'(tx_last), 0);
    check("rst_mid_data",   32'(tx_data), 0);
    check("rst_mid_frames", frames_sent, 0);
    check("rst_mid_seg",    32'(seg_out), 0);
    check("rst_mid_aux",    32'(aux_out), 0);
    check("rst_mid_state",  32'(state), 0);
    repeat (5) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
